helen_nios_2_cpu_debug_host_jtag: RTL
=====================================

HELEN_NIOS_2_CPU_DEBUG_HOST_JTAG -- requirements
Module: helen_nios_2_cpu_debug_host_jtag

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning tck half-period in clk cycles (legal 1..255).
REQ-002 SHALL have parameter DR_WIDTH, default 38, meaning data-register scan length in bits.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1, scan command present.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_ir, input, 2, instruction to load into the debug slave.
REQ-008 SHALL have port cmd_dr, input, DR_WIDTH, data to shift in, LSB first.
REQ-009 SHALL have port rsp_valid, output, 1, scan result available.
REQ-010 SHALL have port rsp_ready, input, 1, result consumed when high together with rsp_valid.
REQ-011 SHALL have port rsp_dr, output, DR_WIDTH, bits captured from tdo.
REQ-012 SHALL have port rsp_ir, output, 2, ir_out value captured during the UIR phase.
REQ-013 SHALL have ports tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, outputs, 1 each, and ir_in, output, 2: the virtual-JTAG drive toward the debug slave.
REQ-014 SHALL have ports tdo, input, 1, and ir_out, input, 2: the return path from the debug slave.

Function
REQ-015 SHALL generate tck from a clk-based divider: low for TCK_DIV clk cycles, then high for TCK_DIV clk cycles (one "period"); tck is 0 whenever the FSM is IDLE or DONE.
REQ-016 SHALL use the FSM states IDLE, UIR, CDR, SDR, UDR, RTI, DONE, each non-idle scan state lasting whole periods.
REQ-017 SHALL have cmd_ready = 1 only in IDLE; on accept it SHALL latch cmd_ir/cmd_dr and enter UIR on the next clk edge.
REQ-018 SHALL stay in UIR for 1 period with vs_uir=1 and ir_in=latched cmd_ir; ir_in SHALL hold that value until the next accept.
REQ-019 SHALL stay in CDR for 1 period with vs_cdr=1.
REQ-020 SHALL stay in SDR for DR_WIDTH periods with vs_sdr=1; during shift period k (0-based), tdi SHALL equal latched cmd_dr[k].
REQ-021 SHALL change tdi, vs_* and jtag_state_rti only at period start (tck falling edge/low phase entry), never while tck=1.
REQ-022 SHALL capture tdo into rsp_dr[k] on the clk edge at which tck rises during shift period k.
REQ-023 SHALL capture ir_out into rsp_rsp_ir… specifically into rsp_ir on the tck-rise clk edge of the UIR period.
REQ-024 SHALL stay in UDR for 1 period with vs_udr=1, then in RTI for 1 period with jtag_state_rti=1.
REQ-025 SHALL enter DONE after RTI, asserting rsp_valid exactly (DR_WIDTH+4)*2*TCK_DIV clk cycles after the accept edge (168 with defaults).
REQ-026 SHALL hold rsp_valid, rsp_dr and rsp_ir stable until rsp_ready=1; it SHALL then return to IDLE on that edge, with cmd_ready=1 on the following cycle.
REQ-027 SHALL hold at most one vs_* / jtag_state_rti signal high at any time; all are 0 in IDLE and DONE.
REQ-028 SHALL ignore cmd_valid outside IDLE; cmd_* changes after accept SHALL NOT affect the scan.
REQ-029 SHALL keep tdi=0 outside SDR.

Reset
REQ-030 SHALL, on a clk edge with reset_n=0, enter IDLE, set tck, tdi, all vs_*, jtag_state_rti, rsp_valid to 0, ir_in to 2'b00, rsp_dr/rsp_ir to 0, and cmd_ready to 0 while reset_n=0.
REQ-031 SHALL abandon a scan in progress on reset with no partial rsp_valid; cmd_ready SHALL be 1 on the first cycle after reset_n returns high.

Verification
REQ-032 SHALL be covered: TCK_DIV=2, cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A with slave tdo loopback of tdi delayed one period -> rsp_valid at cycle 168, rsp_dr = cmd_dr shifted left 1 (bit0 = CDR value).
REQ-033 SHALL be covered: tdo tied 1, ir_out=2'b10 -> rsp_dr=38'h3F_FFFF_FFFF, rsp_ir=2'b10; vs_uir/cdr/sdr/udr/rti high for 4/4/152/4/4 clk cycles respectively.
REQ-034 SHALL be covered: rsp_ready held 0 for 50 cycles after rsp_valid -> rsp_valid and rsp_dr stable, cmd_ready=0, tck=0 throughout.
REQ-035 SHALL be covered: reset_n=0 for 1 cycle at shift bit 20 -> all outputs reset next edge, no rsp_valid, new command then completes normally in 168 cycles.
REQ-036 SHALL be covered: TCK_DIV=1, back-to-back commands with rsp_ready=1 -> each rsp_valid 84 cycles after accept, tck period 2 cycles, tdi never changes while tck=1.

Source files
------------

// File: rtl/helen_nios_2_cpu_debug_host_jtag.sv
// rtl/helen_nios_2_cpu_debug_host_jtag.sv - virtual-JTAG host that scans IR/DR into the Nios II debug slave
module helen_nios_2_cpu_debug_host_jtag #(
  parameter int TCK_DIV  = 2,
  parameter int DR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [1:0]          rsp_ir,
  output logic                tck,
  output logic                tdi,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti,
  output logic [1:0]          ir_in,
  input  logic                tdo,
  input  logic [1:0]          ir_out
);

  localparam int DIV_W = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
  localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  // Divider phase values: last count of a period, the count after which tck rises,
  // and the first count of the high half.
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(TCK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    div_nxt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    bit_nxt;
  logic [DR_WIDTH-1:0] dr_lat;
  logic [DR_WIDTH-1:0] dr_nxt;
  logic [1:0]          ir_nxt;
  logic                accept;
  logic                period_end;
  logic                rise_edge;
  logic                scan_nxt;

  // Ready is gated by reset_n so it reads 0 for the whole time reset is held.
  assign cmd_ready  = reset_n && (state == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign period_end = (div_cnt == DIV_LAST);
  assign rise_edge  = (div_cnt == DIV_RISE);
  assign scan_nxt   = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);

  // Next-state logic: every scan state advances only at the end of a full tck period.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    dr_nxt    = dr_lat;
    ir_nxt    = ir_in;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_UIR;
          div_nxt   = '0;
          bit_nxt   = '0;
          dr_nxt    = cmd_dr;
          ir_nxt    = cmd_ir;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        div_nxt = period_end ? '0 : div_cnt + 1'b1;
        if (period_end) begin
          case (state)
            ST_UIR: state_nxt = ST_CDR;
            ST_CDR: state_nxt = ST_SDR;
            ST_SDR: begin
              if (bit_cnt == BIT_LAST) begin
                state_nxt = ST_UDR;
                bit_nxt   = '0;
              end else begin
                bit_nxt = bit_cnt + 1'b1;
              end
            end
            ST_UDR:  state_nxt = ST_RTI;
            ST_RTI:  state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // State register plus the scan counters and latched command.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      dr_lat  <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      dr_lat  <= dr_nxt;
    end
  end

  // Registered JTAG drive derived from next state, so tdi and vs_* only move when tck falls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tck            <= 1'b0;
      tdi            <= 1'b0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b0;
      ir_in          <= 2'b00;
      rsp_valid      <= 1'b0;
    end else begin
      tck            <= scan_nxt && (div_nxt >= DIV_HIGH);
      tdi            <= (state_nxt == ST_SDR) ? dr_nxt[bit_nxt] : 1'b0;
      vs_uir         <= (state_nxt == ST_UIR);
      vs_cdr         <= (state_nxt == ST_CDR);
      vs_sdr         <= (state_nxt == ST_SDR);
      vs_udr         <= (state_nxt == ST_UDR);
      jtag_state_rti <= (state_nxt == ST_RTI);
      ir_in          <= ir_nxt;
      rsp_valid      <= (state_nxt == ST_DONE);
    end
  end

  // Sample the slave return path on the clk edge where tck rises.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_dr <= '0;
      rsp_ir <= 2'b00;
    end else begin
      if ((state == ST_SDR) && rise_edge) begin
        rsp_dr[bit_cnt] <= tdo;
      end
      if ((state == ST_UIR) && rise_edge) begin
        rsp_ir <= ir_out;
      end
    end
  end

endmodule
